// File: rtl/isr_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : isr_seq_pkg
//  Brief   : FSM state encoding and context-frame layout for isr_sequencer.
//  Revision: 1.0  initial release
// ============================================================================
package isr_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACK     = 2'd1,
        S_SERVICE = 2'd2,
        S_RETURN  = 2'd3
    } state_e;

    // A frame is packed as {pc, acc, id}; id sits at bit 0.
    localparam int ID_W    = 2;
    localparam int ID_LSB  = 0;
    localparam int ACC_LSB = ID_LSB + ID_W;

    function automatic int pc_lsb(input int data_w);
        return ACC_LSB + data_w;
    endfunction

    function automatic int frame_w(input int addr_w, input int data_w);
        return addr_w + data_w + ID_W;
    endfunction

endpackage : isr_seq_pkg
`default_nettype wire

// File: rtl/isr_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module  : isr_sequencer_if
//  Brief   : Controller/core-facing signal bundle of the interrupt sequencer.
//  Revision: 1.0  initial release
// ============================================================================
interface isr_sequencer_if
    import isr_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              i_pending;
    logic [ADDR_W-1:0] isr_vec;
    logic [ID_W-1:0]   itr_id;
    logic              instr_done;
    logic              reti;
    logic [ADDR_W-1:0] pc_cur;
    logic [DATA_W-1:0] acc_cur;

    logic              itr_en;
    logic              itr_clr;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_next;
    logic              acc_restore;
    logic [DATA_W-1:0] acc_out;
    logic              in_service;
    logic [ID_W-1:0]   ack_id;
    logic              err_reti;

    modport master (
        output i_pending, isr_vec, itr_id, instr_done, reti, pc_cur, acc_cur,
        input  itr_en, itr_clr, pc_load, pc_next, acc_restore, acc_out,
               in_service, ack_id, err_reti
    );

    modport slave (
        input  i_pending, isr_vec, itr_id, instr_done, reti, pc_cur, acc_cur,
        output itr_en, itr_clr, pc_load, pc_next, acc_restore, acc_out,
               in_service, ack_id, err_reti
    );

endinterface : isr_sequencer_if
`default_nettype wire

// File: rtl/isr_sequencer_frame_stack.sv
`default_nettype none
// ============================================================================
//  Module  : isr_frame_stack
//  Brief   : DEPTH x FRAME_W LIFO of saved interrupt contexts, saturating count.
//  Revision: 1.0  initial release
// ============================================================================
module isr_frame_stack #(
    parameter  int DEPTH   = 1,
    parameter  int FRAME_W = 18,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  wire logic               clk,
    input  wire logic               clr,
    input  wire logic               push_i,
    input  wire logic               pop_i,
    input  wire logic [FRAME_W-1:0] push_data_i,
    output logic      [FRAME_W-1:0] top_o,
    output logic      [CNT_W-1:0]   count_o,
    output logic                    full_o,
    output logic                    empty_o
);

    logic [FRAME_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]   count_q;

    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    always_comb begin
        top_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (count_q == CNT_W'(i + 1)) begin
                top_o = mem_q[i];
            end
        end
    end

    // Push takes precedence over pop; the sequencer never requests both at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (count_q == CNT_W'(i)) begin
                    mem_q[i] <= push_data_i;
                end
            end
            count_q <= count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

endmodule : isr_frame_stack
`default_nettype wire

// File: rtl/isr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : isr_sequencer
//  Brief   : Accepts interrupts at instruction boundaries, saves PC/ACC, vectors
//            to the ISR and restores context on RETI. Define ISR_NESTING_EN to
//            allow higher-priority preemption with DEPTH context frames.
//  Revision: 1.0  initial release
// ============================================================================
module isr_sequencer
    import isr_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input wire logic        clk,
    input wire logic        clr,
    isr_sequencer_if.slave  bus
);

`ifdef ISR_NESTING_EN
    localparam bit NEST_EN = 1'b1;
`else
    localparam bit NEST_EN = 1'b0;
`endif
    localparam int STK_DEPTH = NEST_EN ? DEPTH : 1;
    localparam int FRAME_W   = frame_w(ADDR_W, DATA_W);
    localparam int PC_LSB    = pc_lsb(DATA_W);
    localparam int CNT_W     = $clog2(STK_DEPTH + 1);

    state_e            state_q;
    logic              itr_en_q;
    logic              itr_clr_q;
    logic              pc_load_q;
    logic [ADDR_W-1:0] pc_next_q;
    logic              acc_restore_q;
    logic [DATA_W-1:0] acc_out_q;
    logic              in_service_q;
    logic [ID_W-1:0]   ack_id_q;
    logic              err_reti_q;

    logic [FRAME_W-1:0] w_push_frame;
    logic [FRAME_W-1:0] w_top;
    logic [CNT_W-1:0]   w_count;
    logic               w_full;
    logic               w_empty;
    logic               w_take;
    logic               w_reti_act;
    logic               w_preempt;
    logic               w_push;
    logic               w_pop;

    assign w_push_frame = {bus.pc_cur, bus.acc_cur, bus.itr_id};
    assign w_take       = bus.i_pending & bus.instr_done & ~w_full;
    assign w_reti_act   = bus.reti & bus.instr_done;
    // Preemption needs strictly higher priority (lower id); a same-cycle reti wins.
    assign w_preempt    = NEST_EN & (state_q == S_SERVICE) & ~w_reti_act
                        & (bus.itr_id < ack_id_q);
    assign w_push       = w_take & ((state_q == S_IDLE) | w_preempt);
    assign w_pop        = (state_q == S_SERVICE) & w_reti_act & ~w_empty;

    isr_frame_stack #(
        .DEPTH   (STK_DEPTH),
        .FRAME_W (FRAME_W)
    ) u_stack (
        .clk         (clk),
        .clr         (clr),
        .push_i      (w_push),
        .pop_i       (w_pop),
        .push_data_i (w_push_frame),
        .top_o       (w_top),
        .count_o     (w_count),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // Outputs are registered with the state they belong to, so each strobe
    // appears exactly in the cycle its state is occupied.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q       <= S_IDLE;
            itr_en_q      <= 1'b1;
            itr_clr_q     <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_next_q     <= '0;
            acc_restore_q <= 1'b0;
            acc_out_q     <= '0;
            in_service_q  <= 1'b0;
            ack_id_q      <= '0;
            err_reti_q    <= 1'b0;
        end else begin
            itr_clr_q     <= 1'b0;
            pc_load_q     <= 1'b0;
            acc_restore_q <= 1'b0;

            if (w_reti_act && (w_count == '0)
                && ((state_q == S_IDLE) || (state_q == S_SERVICE))) begin
                err_reti_q <= 1'b1;
            end

            unique case (state_q)
                S_IDLE, S_SERVICE: begin
                    if (w_pop) begin
                        state_q       <= S_RETURN;
                        pc_load_q     <= 1'b1;
                        pc_next_q     <= w_top[PC_LSB +: ADDR_W];
                        acc_restore_q <= 1'b1;
                        acc_out_q     <= w_top[ACC_LSB +: DATA_W];
                        in_service_q  <= 1'b0;
                        itr_en_q      <= 1'b0;
                    end else if (w_push) begin
                        state_q      <= S_ACK;
                        pc_load_q    <= 1'b1;
                        pc_next_q    <= bus.isr_vec;
                        itr_clr_q    <= 1'b1;
                        itr_en_q     <= 1'b0;
                        in_service_q <= 1'b0;
                    end
                end
                S_ACK: begin
                    state_q      <= S_SERVICE;
                    in_service_q <= 1'b1;
                    ack_id_q     <= w_top[ID_LSB +: ID_W];
                    itr_en_q     <= NEST_EN;
                end
                S_RETURN: begin
                    if (w_empty) begin
                        state_q  <= S_IDLE;
                        itr_en_q <= 1'b1;
                        ack_id_q <= '0;
                    end else begin
                        state_q      <= S_SERVICE;
                        in_service_q <= 1'b1;
                        ack_id_q     <= w_top[ID_LSB +: ID_W];
                        itr_en_q     <= NEST_EN;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.itr_en      = itr_en_q;
    assign bus.itr_clr     = itr_clr_q;
    assign bus.pc_load     = pc_load_q;
    assign bus.pc_next     = pc_next_q;
    assign bus.acc_restore = acc_restore_q;
    assign bus.acc_out     = acc_out_q;
    assign bus.in_service  = in_service_q;
    assign bus.ack_id      = ack_id_q;
    assign bus.err_reti    = err_reti_q;

endmodule : isr_sequencer
`default_nettype wire

// File: tb/tb_isr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_isr_sequencer
//  Brief   : Directed self-checking bench for isr_sequencer (both nesting builds).
//  Revision: 1.0  initial release
// ============================================================================
module tb_isr_sequencer;

    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    isr_sequencer_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    isr_sequencer #(.ADDR_W(8), .DATA_W(8), .DEPTH(2)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic p, input logic d, input logic r, input logic [1:0] id,
                         input logic [7:0] vec, input logic [7:0] pc, input logic [7:0] acc);
        bus.i_pending  = p;
        bus.instr_done = d;
        bus.reti       = r;
        bus.itr_id     = id;
        bus.isr_vec    = vec;
        bus.pc_cur     = pc;
        bus.acc_cur    = acc;
    endtask

    initial begin
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        #1 clr = 1'b0;
        tick(); tick();
        chk("rst_itr_en",      32'(bus.itr_en),      32'h1);
        chk("rst_itr_clr",     32'(bus.itr_clr),     32'h0);
        chk("rst_pc_load",     32'(bus.pc_load),     32'h0);
        chk("rst_acc_restore", 32'(bus.acc_restore), 32'h0);
        chk("rst_in_service",  32'(bus.in_service),  32'h0);
        chk("rst_pc_next",     32'(bus.pc_next),     32'h0);
        chk("rst_acc_out",     32'(bus.acc_out),     32'h0);
        chk("rst_ack_id",      32'(bus.ack_id),      32'h0);
        chk("rst_err_reti",    32'(bus.err_reti),    32'h0);
        clr = 1'b1;
        tick();

        // basic entry and return
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h96, 8'h21, 8'h5A);
        tick();
        chk("basic_ack_pc_load", 32'(bus.pc_load), 32'h1);
        chk("basic_ack_pc_next", 32'(bus.pc_next), 32'h96);
        chk("basic_ack_itr_clr", 32'(bus.itr_clr), 32'h1);
        chk("basic_ack_itr_en",  32'(bus.itr_en),  32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h97, 8'h33);
        tick();
        chk("basic_svc_in_service", 32'(bus.in_service), 32'h1);
        chk("basic_svc_ack_id",     32'(bus.ack_id),     32'h1);
        chk("basic_svc_pc_load",    32'(bus.pc_load),    32'h0);
        chk("basic_svc_itr_clr",    32'(bus.itr_clr),    32'h0);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 8'h97, 8'h33);
        tick();
        chk("basic_ret_pc_load",     32'(bus.pc_load),     32'h1);
        chk("basic_ret_pc_next",     32'(bus.pc_next),     32'h21);
        chk("basic_ret_acc_restore", 32'(bus.acc_restore), 32'h1);
        chk("basic_ret_acc_out",     32'(bus.acc_out),     32'h5A);
        chk("basic_ret_in_service",  32'(bus.in_service),  32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h21, 8'h5A);
        tick();
        chk("basic_idle_itr_en",      32'(bus.itr_en),      32'h1);
        chk("basic_idle_in_service",  32'(bus.in_service),  32'h0);
        chk("basic_idle_pc_load",     32'(bus.pc_load),     32'h0);
        chk("basic_idle_acc_restore", 32'(bus.acc_restore), 32'h0);

        // pending held without an instruction boundary
        drive(1'b1, 1'b0, 1'b0, 2'd2, 8'h40, 8'h50, 8'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bnd_wait_pc_load", 32'(bus.pc_load), 32'h0);
            chk("bnd_wait_itr_clr", 32'(bus.itr_clr), 32'h0);
        end
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h40, 8'h50, 8'h11);
        tick();
        chk("bnd_ack_pc_load", 32'(bus.pc_load), 32'h1);
        chk("bnd_ack_pc_next", 32'(bus.pc_next), 32'h40);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h41, 8'h00);
        tick();
        chk("bnd_svc_ack_id", 32'(bus.ack_id), 32'h2);
        drive(1'b0, 1'b0, 1'b1, 2'd0, 8'h00, 8'h41, 8'h00);
        tick();
        chk("bnd_reti_nodone_in_service", 32'(bus.in_service), 32'h1);
        chk("bnd_reti_nodone_pc_load",    32'(bus.pc_load),    32'h0);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 8'h41, 8'h00);
        tick();
        chk("bnd_ret_pc_next", 32'(bus.pc_next), 32'h50);
        chk("bnd_ret_acc_out", 32'(bus.acc_out), 32'h11);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h50, 8'h11);
        tick();
        chk("bnd_idle_in_service", 32'(bus.in_service), 32'h0);

        // spurious reti in IDLE
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 8'h00, 8'h00);
        tick();
        chk("spur_err_reti", 32'(bus.err_reti), 32'h1);
        chk("spur_pc_load",  32'(bus.pc_load),  32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        tick(); tick();
        chk("spur_err_sticky", 32'(bus.err_reti), 32'h1);
        chk("spur_itr_en",     32'(bus.itr_en),   32'h1);

        // reti collides with a new pending interrupt
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'hA0, 8'h60, 8'h77);
        tick();
        chk("col_ack_pc_next", 32'(bus.pc_next), 32'hA0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'hA1, 8'h00);
        tick();
        chk("col_svc_in_service", 32'(bus.in_service), 32'h1);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 8'hB0, 8'hA5, 8'h22);
        tick();
        chk("col_ret_pc_load",     32'(bus.pc_load),     32'h1);
        chk("col_ret_pc_next",     32'(bus.pc_next),     32'h60);
        chk("col_ret_acc_restore", 32'(bus.acc_restore), 32'h1);
        chk("col_ret_acc_out",     32'(bus.acc_out),     32'h77);
        chk("col_ret_itr_clr",     32'(bus.itr_clr),     32'h0);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hB0, 8'h60, 8'h77);
        tick();
        chk("col_idle_pc_load",    32'(bus.pc_load),    32'h0);
        chk("col_idle_in_service", 32'(bus.in_service), 32'h0);
        chk("col_idle_itr_en",     32'(bus.itr_en),     32'h1);
        tick();
        chk("col_reack_pc_load", 32'(bus.pc_load), 32'h1);
        chk("col_reack_pc_next", 32'(bus.pc_next), 32'hB0);
        chk("col_reack_itr_clr", 32'(bus.itr_clr), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'hB1, 8'h00);
        tick();
        chk("col_svc_ack_id", 32'(bus.ack_id), 32'h3);
`ifndef ISR_NESTING_EN
        drive(1'b1, 1'b1, 1'b0, 2'd0, 8'hC0, 8'hB2, 8'h00);
        tick();
        chk("flat_ignore_pc_load",    32'(bus.pc_load),    32'h0);
        chk("flat_ignore_itr_clr",    32'(bus.itr_clr),    32'h0);
        chk("flat_ignore_in_service", 32'(bus.in_service), 32'h1);
        chk("flat_ignore_itr_en",     32'(bus.itr_en),     32'h0);
`endif

        // asynchronous reset in the middle of an ISR
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00, 8'h00);
        clr = 1'b0;
        #1;
        chk("arst_itr_en",     32'(bus.itr_en),     32'h1);
        chk("arst_in_service", 32'(bus.in_service), 32'h0);
        chk("arst_pc_load",    32'(bus.pc_load),    32'h0);
        chk("arst_ack_id",     32'(bus.ack_id),     32'h0);
        tick();
        chk("arst_no_restore", 32'(bus.acc_restore), 32'h0);
        clr = 1'b1;
        tick();
        chk("arst_rel_in_service", 32'(bus.in_service), 32'h0);
        chk("arst_rel_err_reti",   32'(bus.err_reti),   32'h0);
        chk("arst_rel_pc_load",    32'(bus.pc_load),    32'h0);

`ifdef ISR_NESTING_EN
        drive(1'b1, 1'b1, 1'b0, 2'd2, 8'h80, 8'h10, 8'h01);
        tick();
        chk("nest_ack_itr_en",  32'(bus.itr_en),  32'h0);
        chk("nest_ack_pc_next", 32'(bus.pc_next), 32'h80);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h81, 8'h00);
        tick();
        chk("nest_svc_ack_id", 32'(bus.ack_id), 32'h2);
        chk("nest_svc_itr_en", 32'(bus.itr_en), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'd1, 8'h90, 8'h83, 8'h02);
        tick();
        chk("nest_pre_pc_load", 32'(bus.pc_load), 32'h1);
        chk("nest_pre_pc_next", 32'(bus.pc_next), 32'h90);
        chk("nest_pre_itr_en",  32'(bus.itr_en),  32'h0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h91, 8'h00);
        tick();
        chk("nest_inner_ack_id", 32'(bus.ack_id), 32'h1);
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 8'h91, 8'h00);
        tick();
        chk("nest_inner_ret_pc_next", 32'(bus.pc_next), 32'h83);
        chk("nest_inner_ret_acc_out", 32'(bus.acc_out), 32'h02);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h83, 8'h02);
        tick();
        chk("nest_resume_ack_id",     32'(bus.ack_id),     32'h2);
        chk("nest_resume_in_service", 32'(bus.in_service), 32'h1);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hA0, 8'h84, 8'h03);
        tick();
        chk("nest_low_held_pc_load", 32'(bus.pc_load), 32'h0);
        chk("nest_low_held_ack_id",  32'(bus.ack_id),  32'h2);
        drive(1'b1, 1'b1, 1'b1, 2'd3, 8'hA0, 8'h84, 8'h03);
        tick();
        chk("nest_outer_ret_pc_next", 32'(bus.pc_next), 32'h10);
        chk("nest_outer_ret_acc_out", 32'(bus.acc_out), 32'h01);
        drive(1'b1, 1'b1, 1'b0, 2'd3, 8'hA0, 8'h10, 8'h01);
        tick();
        chk("nest_idle_in_service", 32'(bus.in_service), 32'h0);
        chk("nest_idle_pc_load",    32'(bus.pc_load),    32'h0);
        tick();
        chk("nest_low_ack_pc_load", 32'(bus.pc_load), 32'h1);
        chk("nest_low_ack_pc_next", 32'(bus.pc_next), 32'hA0);
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'hA1, 8'h00);
        tick();
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h00, 8'hA1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h10, 8'h01);
        tick();
        chk("nest_end_in_service", 32'(bus.in_service), 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_isr_sequencer
`default_nettype wire
